// File: rtl/switch_led_pkg.sv
// Shared types and helpers for the front-panel switch/LED controller.
// Holds the mode encoding, the mode-advance rule and the synchroniser depth.
package switch_led_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_COUNT  = 2'd2
  } mode_e;

  localparam int SYNC_STAGES = 2;

  // Advances one step per button press. The unused encoding falls back to DIRECT.
  function automatic mode_e mode_next(mode_e cur);
    case (cur)
      MODE_DIRECT: mode_next = MODE_TOGGLE;
      MODE_TOGGLE: mode_next = MODE_COUNT;
      default:     mode_next = MODE_DIRECT;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One input channel: a 2-flop synchroniser followed by a debounce counter.
// The stable output is active high and changes only after a full stable window.
module sw_debounce
  import switch_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_n,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   level;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pin_n};
    level    = ~sync_q[SYNC_STAGES-1];
    stable_d = stable_q;
    cnt_d    = '0;
    // Any sample that agrees with the accepted level restarts the window.
    if (level != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = level;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: synchroniser flops reset to 1 because the pins idle high (released);
  // resetting them to 0 would look like a press entering the debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/switch_led_ctrl.sv
// Front-panel controller: debounced switches drive LEDs directly, as toggles
// or as a press counter, selected by a debounced mode button.
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int                NUM_SW          = 4,
  parameter int                DEBOUNCE_CYCLES = 12000,
  parameter logic [NUM_SW-1:0] LED_INVERT      = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] switch_n,
  input  logic              mode_btn_n,
  output logic [NUM_SW-1:0] led,
  output logic [1:0]        mode,
  output logic [NUM_SW-1:0] pressed
);

  logic [NUM_SW:0]   pins_n;
  logic [NUM_SW:0]   stable;
  logic [NUM_SW-1:0] pressed_q, pressed_d;
  logic              mode_btn_q, mode_btn_d;
  logic [NUM_SW-1:0] rise;
  logic              mode_rise;
  mode_e             mode_q, mode_d;
  logic [NUM_SW-1:0] latch_q, latch_d;
  logic [NUM_SW-1:0] count_q, count_d;
  logic [NUM_SW-1:0] led_q, led_d;
  logic [NUM_SW-1:0] led_logic;

  assign pins_n = {mode_btn_n, switch_n};

  for (genvar gi = 0; gi <= NUM_SW; gi++) begin : g_ch
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .pin_n (pins_n[gi]),
      .stable(stable[gi])
    );
  end

  assign pressed   = stable[NUM_SW-1:0];
  assign pressed_d = pressed;
  assign mode_btn_d = stable[NUM_SW];
  assign rise      = pressed & ~pressed_q;
  assign mode_rise = stable[NUM_SW] & ~mode_btn_q;

  // Mode FSM: next state.
  always_comb begin
    case (mode_q)
      MODE_DIRECT, MODE_TOGGLE, MODE_COUNT:
        mode_d = mode_rise ? mode_next(mode_q) : mode_q;
      default:
        mode_d = MODE_DIRECT;
    endcase
  end

  // Mode FSM: outputs.
  always_comb begin
    mode = mode_q;
  end

  // A mode change wins over switch edges arriving in the same cycle.
  always_comb begin
    latch_d = latch_q;
    count_d = count_q;
    if (mode_rise) begin
      if (mode_d == MODE_TOGGLE) latch_d = '0;
      if (mode_d == MODE_COUNT)  count_d = '0;
    end else begin
      case (mode_q)
        MODE_TOGGLE: latch_d = latch_q ^ rise;
        MODE_COUNT:  if (|rise) count_d = count_q + NUM_SW'(1);
        default: ;
      endcase
    end
  end

  // Next-state values feed the LED register so an edge shows one cycle later.
  always_comb begin
    case (mode_d)
      MODE_DIRECT: led_logic = pressed;
      MODE_TOGGLE: led_logic = latch_d;
      MODE_COUNT:  led_logic = count_d;
      default:     led_logic = '0;
    endcase
    led_d = led_logic ^ LED_INVERT;
  end

  // NOTE: every state flop uses non-blocking assignment so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_q  <= '0;
      mode_btn_q <= 1'b0;
      mode_q     <= MODE_DIRECT;
      latch_q    <= '0;
      count_q    <= '0;
      led_q      <= LED_INVERT;
    end else begin
      pressed_q  <= pressed_d;
      mode_btn_q <= mode_btn_d;
      mode_q     <= mode_d;
      latch_q    <= latch_d;
      count_q    <= count_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Scoreboard bench for switch_led_ctrl: stimulus queues each expected output
// change, a monitor pops one entry per observed change of {led, mode, pressed}.
module tb_switch_led_ctrl;

  localparam int         NSW = 4;
  localparam int         DB  = 4;
  localparam logic [3:0] INV = 4'b0010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] switch_n;
  logic       mode_btn_n;
  logic [3:0] led;
  logic [1:0] mode;
  logic [3:0] pressed;

  switch_led_ctrl #(
    .NUM_SW         (NSW),
    .DEBOUNCE_CYCLES(DB),
    .LED_INVERT     (INV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch_n  (switch_n),
    .mode_btn_n(mode_btn_n),
    .led       (led),
    .mode      (mode),
    .pressed   (pressed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [9:0] val;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] led_exp  = INV;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input string name, input logic [3:0] l, input logic [1:0] m,
                      input logic [3:0] p, input int at);
    exp_t e;
    e.name = name;
    e.val  = {l, m, p};
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the channels in m for hold cycles, then release; queue the four
  // possible output changes (press, led, release, led).
  task automatic tap(input logic [3:0] m, input int hold, input logic [1:0] md,
                     input logic [3:0] led_new, input logic [3:0] led_rel);
    int n;
    n = cyc;
    push("press", led_exp, md, m, n + DB + 2);
    if (led_new != led_exp) push("led_on_press", led_new, md, m, n + DB + 3);
    push("release", led_new, md, 4'b0000, n + hold + DB + 2);
    if (led_rel != led_new) push("led_on_release", led_rel, md, 4'b0000, n + hold + DB + 3);
    led_exp = led_rel;
    switch_n = switch_n & ~m;
    idle(hold);
    switch_n = switch_n | m;
    idle(10);
  endtask

  task automatic mode_press(input logic [1:0] new_mode);
    push("mode_step", led_exp, new_mode, 4'b0000, cyc + DB + 3);
    mode_btn_n = 1'b0;
    idle(10);
    mode_btn_n = 1'b1;
    idle(10);
  endtask

  initial begin : monitor
    logic [9:0] last;
    logic [9:0] cur;
    exp_t       e;
    last = 'x;
    forever begin
      @(negedge clk);
      cur = {led, mode, pressed};
      if (cur !== last) begin
        if (sb.size() == 0) begin
          check("unexpected_change", 32'(cur), 32'(last));
        end else begin
          e = sb.pop_front();
          check(e.name, 32'(cur), 32'(e.val));
          if (e.at >= 0) check({e.name, "_cycle"}, cyc, e.at);
        end
        last = cur;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    int r;
    rst_n      = 1'b0;
    switch_n   = 4'hF;
    mode_btn_n = 1'b1;
    push("reset", INV, 2'd0, 4'b0000, -1);
    idle(3);
    rst_n = 1'b1;
    idle(5);

    // DIRECT: press follows pins; short glitch is rejected.
    tap(4'b0001, 6, 2'd0, 4'b0011, 4'b0010);
    switch_n[1] = 1'b0;
    idle(3);
    switch_n[1] = 1'b1;
    idle(12);

    // TOGGLE: each press flips, release and hold do nothing.
    mode_press(2'd1);
    tap(4'b0100, 6, 2'd1, 4'b0110, 4'b0110);
    tap(4'b0100, 6, 2'd1, 4'b0010, 4'b0010);
    tap(4'b0100, 50, 2'd1, 4'b0110, 4'b0110);

    // Walk round to DIRECT, then two presses to COUNT (counter cleared).
    led_exp = INV;
    mode_press(2'd2);
    mode_press(2'd0);
    mode_press(2'd1);
    mode_press(2'd2);

    // COUNT: 17 presses wrap 15 -> 0 and land on 1.
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] cv;
      cv = 4'(k % 16) ^ INV;
      tap(4'b1000, 6, 2'd2, cv, cv);
    end
    tap(4'b0011, 6, 2'd2, 4'b0000, 4'b0000);

    // Mode rise coincident with a switch rise: mode wins, DIRECT shows pressed.
    n = cyc;
    push("coinc_press", 4'b0000, 2'd2, 4'b0001, n + 6);
    push("coinc_mode", 4'b0011, 2'd0, 4'b0001, n + 7);
    push("coinc_release", 4'b0011, 2'd0, 4'b0000, n + 16);
    push("coinc_led_off", 4'b0010, 2'd0, 4'b0000, n + 17);
    switch_n[0] = 1'b0;
    mode_btn_n  = 1'b0;
    idle(10);
    switch_n[0] = 1'b1;
    mode_btn_n  = 1'b1;
    idle(12);
    led_exp = INV;
    mode_press(2'd1);
    mode_press(2'd2);
    mode_press(2'd0);

    // Async reset while TOGGLE is lit and another channel is mid-debounce.
    mode_press(2'd1);
    n = cyc;
    push("hold_press", 4'b0010, 2'd1, 4'b0010, n + 6);
    push("hold_toggle", 4'b0000, 2'd1, 4'b0010, n + 7);
    switch_n[1] = 1'b0;
    idle(8);
    switch_n[3] = 1'b0;
    idle(2);
    #3;
    push("async_reset", INV, 2'd0, 4'b0000, -1);
    rst_n = 1'b0;
    #1;
    check("reset_immediate", 32'({led, mode, pressed}), 32'({INV, 2'd0, 4'b0000}));
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    r = cyc;
    push("post_reset_press", 4'b0010, 2'd0, 4'b1010, r + 6);
    push("post_reset_led", 4'b1000, 2'd0, 4'b1010, r + 7);
    idle(10);
    n = cyc;
    push("post_reset_release", 4'b1000, 2'd0, 4'b0000, n + 6);
    push("post_reset_led_off", 4'b0010, 2'd0, 4'b0000, n + 7);
    switch_n = 4'hF;
    idle(14);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_led_ctrl.md
Name: switch_led_ctrl

Overview:
Parametrised front-panel controller that turns NUM_SW active-low board switches into NUM_SW LED outputs. Each switch input is synchronised and debounced. A dedicated active-low mode button cycles the LED function through DIRECT, TOGGLE and COUNT. It sits between the board switch/button pins and the LED pins, replacing the fixed combinational switch decode.

Parameters:
NUM_SW, 4, number of switch channels and LED outputs (1..8)
DEBOUNCE_CYCLES, 12000, consecutive stable cycles needed to accept a level change (1 ms at 12 MHz; must be >= 1)
LED_INVERT, {NUM_SW{1'b0}}, per-LED output inversion mask for active-low LEDs

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
switch_n  input  NUM_SW  raw switch pins, active low (pressed = 0), asynchronous to clk
mode_btn_n  input  1  raw mode button pin, active low, asynchronous to clk
led  output  NUM_SW  LED drive after the LED_INVERT mask, registered
mode  output  2  current mode: 0 DIRECT, 1 TOGGLE, 2 COUNT, registered
pressed  output  NUM_SW  debounced pressed state, active high, registered

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low: assertion acts immediately; deassertion is used synchronously.
- Reset values:
  - sync flops = 1 (released)
  - debounced state = released; pressed = 0
  - debounce counters = 0
  - mode = 0 (DIRECT)
  - toggle latches = 0; press counter = 0
  - led = LED_INVERT (logical 0 on every LED)
- Synchronisation: each of the NUM_SW+1 raw inputs passes through a 2-flop synchroniser, then is inverted to active high.
- Debounce (per channel, including the mode button):
  - counter clears whenever sync == stable.
  - While sync != stable, counter increments each cycle.
  - On the cycle counter == DEBOUNCE_CYCLES-1 with sync still != stable: stable <= sync, counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
  - Edge latency from a pin change to a pressed change is 2 + DEBOUNCE_CYCLES cycles.
- Edge detect: rise[i] = pressed[i] & ~pressed_q[i], one-cycle pulse per channel; same rule for mode_rise.
- Mode FSM: DIRECT -> TOGGLE -> COUNT -> DIRECT, advancing one step per mode_rise. Mode value 3 is never entered; if it is ever reached, the next cycle goes to DIRECT.
  - Entering TOGGLE clears all toggle latches.
  - Entering COUNT clears the counter.
  - A mode_rise takes priority: switch edges in that same cycle are ignored.
- Mode functions:
  - DIRECT: logical led = pressed.
  - TOGGLE: rise[i] flips latch[i]; logical led = latch. Simultaneous rises on several channels flip each of those channels independently.
  - COUNT: counter (width NUM_SW) increments by exactly 1 in any cycle where at least one rise[i] is set, whatever the number of simultaneous rises. It wraps from 2^NUM_SW-1 to 0. Logical led = counter.
- Output timing: led = logical led XOR LED_INVERT, registered. A switch edge appears on led one cycle after pressed changes.
- Held switches: holding a switch produces no repeat action. A release produces no action in TOGGLE or COUNT.
- Reset mid-operation: all state returns to reset values immediately, including a partly expired debounce count.

Decomposition:
- Package switch_led_pkg holds:
  - mode enum: MODE_DIRECT = 2'd0, MODE_TOGGLE = 2'd1, MODE_COUNT = 2'd2
  - mode-next function
  - synchroniser depth constant SYNC_STAGES = 2
- One sub-module, sw_debounce (parameter DEBOUNCE_CYCLES): one channel of synchroniser + debounce counter + stable flop. It is instantiated NUM_SW+1 times.
- Edge detect, mode FSM, toggle latches, counter and output register stay in the top level.

Test Plan (DEBOUNCE_CYCLES=4, NUM_SW=4, LED_INVERT=4'b0010 for all scenarios):
- Reset, then pins idle high -> pressed=0, mode=0, led=4'b0010. Assert rst_n=0 asynchronously mid-debounce -> the same values appear immediately.
- DIRECT mode: drive switch_n[0]=0 for 6 cycles -> pressed[0]=1 exactly 6 cycles after the pin edge, led=4'b0011 one cycle later. A 3-cycle low pulse on switch_n[1] -> pressed stays 0.
- Mode button held 10 cycles -> mode=1, latches clear, led=4'b0010. Press and release switch 2 twice -> led goes 4'b0110, then 4'b0010. Holding switch 2 for 50 cycles -> only one toggle.
- Press the mode button twice from DIRECT -> mode=2, counter=0. Give 17 single presses of switch 3 -> logical led=4'b0001 (wrap after 15). Simultaneous debounced presses on switches 0 and 1 -> counter +1 only.
- From COUNT, a mode_rise in the same cycle as a switch rise -> mode=0 and the counter is unchanged. Three further mode presses -> mode sequence 1, 2, 0; mode value 3 never appears.
